cache_controller: RTL
=====================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 ADDR_BITS, 32, byte address width.
REQ-002 WORD_BITS, 32, data word width.
REQ-003 TAG_BITS, 22, tag width = addr[ADDR_BITS-1:ADDR_BITS-TAG_BITS].
REQ-004 WORD_BYTES_WIDTH, 2, byte-offset bits.
REQ-005 LINE_WORDS_WIDTH, 2, word-in-line bits (4 words/line); index = addr[ADDR_BITS-TAG_BITS-1:LINE_WORDS_WIDTH+WORD_BYTES_WIDTH].
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 cpu_req  in  1  request valid; sampled only in IDLE.
REQ-010 cpu_we  in  1  1 = write, 0 = read.
REQ-011 cpu_addr  in  ADDR_BITS  request byte address, word aligned.
REQ-012 cpu_din  in  WORD_BITS  write data.
REQ-013 cpu_dout  out  WORD_BITS  read data, valid while cpu_ack=1.
REQ-014 cpu_ack  out  1  one-cycle completion pulse, registered.
REQ-015 cache_addr  out  ADDR_BITS  address to data array.
REQ-016 cache_din  out  WORD_BITS  write data to array.
REQ-017 cache_store  out  1  refill word write: array sets valid=1, dirty=0, tag.
REQ-018 cache_edit  out  1  CPU write hit: array writes word, sets dirty=1.
REQ-019 cache_dout  in  WORD_BITS  array word, registered (1-cycle read latency).
REQ-020 cache_valid  in  1  line valid, same 1-cycle latency.
REQ-021 cache_dirty  in  1  line dirty, same latency.
REQ-022 cache_tag  in  TAG_BITS  line tag, same latency.
REQ-023 mem_cs  out  1  memory request; held until mem_ack.
REQ-024 mem_we  out  1  1 = writeback, 0 = refill read.
REQ-025 mem_addr  out  ADDR_BITS  memory word address.
REQ-026 mem_dout  out  WORD_BITS  writeback data.
REQ-027 mem_din  in  WORD_BITS  refill data, valid with mem_ack.
REQ-028 mem_ack  in  1  memory completion; ignored while mem_cs=0.

Function
REQ-029 States IDLE, LOOKUP, WB_RD, WB_WR, REFILL; cpu_addr/we/din latched on IDLE with cpu_req=1, then LOOKUP; cache_addr = cpu_addr in IDLE, latched address otherwise except as below.
REQ-030 LOOKUP hit = cache_valid & (cache_tag == latched tag); cache_dirty does not affect hit.
REQ-031 Read hit: next edge cpu_dout<=cache_dout, cpu_ack<=1, state IDLE; ack visible 2 cycles after acceptance edge.
REQ-032 Write hit: cache_edit=1, cache_din=latched din for the LOOKUP cycle only; cpu_ack next cycle, state IDLE.
REQ-033 Miss with cache_valid & cache_dirty: victim tag latched, word counter k=0, go WB_RD; otherwise k=0, go REFILL.
REQ-034 WB_RD (1 cycle): cache_addr={index,k,0}; go WB_WR.
REQ-035 WB_WR: cache_addr held, mem_cs=1, mem_we=1, mem_addr={victim tag,index,k,0}, mem_dout=cache_dout; on mem_ack, k==3 ? (k=0, REFILL) : (k+1, WB_RD).
REQ-036 REFILL: mem_cs=1, mem_we=0, mem_addr={req tag,index,k,0}; in mem_ack cycle cache_store=1, cache_addr=mem_addr, cache_din=mem_din; k==3 ? LOOKUP : k+1.
REQ-037 Re-entered LOOKUP after refill SHALL hit and complete per REQ-031/032.
REQ-038 mem_addr/mem_dout/mem_we stable while mem_cs=1 without mem_ack; cache_store/cache_edit never both 1; cpu_req outside IDLE ignored; cpu_req=1 in ack cycle is a new request.

Reset
REQ-039 rst=0 immediately forces IDLE, k=0 and all outputs 0, including mid-writeback/refill; array contents untouched.

Verification
REQ-040 Cold read 0x00000100, mem returns 0xA0..0xA3: 4 reads 0x100..0x10C, 4 cache_store pulses, cpu_dout=0xA0, no mem_we.
REQ-041 Read 0x00000108 next: cpu_ack 2 cycles after acceptance, cpu_dout=0xA2, mem_cs stays 0.
REQ-042 Write 0x00000104 din 0xDEADBEEF: one cache_edit cycle, ack; read 0x104 returns 0xDEADBEEF.
REQ-043 Read 0x00001100 (same index, new tag): writes 0x100..0x10C with 0xA0,0xDEADBEEF,0xA2,0xA3, then refill 0x1100..0x110C; mem_ack delayed 3 cycles holds mem_* stable.
REQ-044 rst=0 during REFILL k=2: mem_cs, cache_store drop at once; after release, no ack until new cpu_req.

Source files
------------

// File: rtl/cache_controller_if.sv
// Bus bundle for the cache controller: CPU request/response, data-array
// access and backing-memory handshake.
//   master : controller side (drives cpu_dout/ack, cache_*, mem_cs/we/addr/dout)
//   slave  : environment side (CPU, data array, memory)
interface cache_controller_if #(
  parameter int ADDR_BITS = 32,
  parameter int WORD_BITS = 32,
  parameter int TAG_BITS  = 22
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [WORD_BITS-1:0] cpu_din;
  logic [WORD_BITS-1:0] cpu_dout;
  logic                 cpu_ack;

  logic [ADDR_BITS-1:0] cache_addr;
  logic [WORD_BITS-1:0] cache_din;
  logic                 cache_store;
  logic                 cache_edit;
  logic [WORD_BITS-1:0] cache_dout;
  logic                 cache_valid;
  logic                 cache_dirty;
  logic [TAG_BITS-1:0]  cache_tag;

  logic                 mem_cs;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [WORD_BITS-1:0] mem_dout;
  logic [WORD_BITS-1:0] mem_din;
  logic                 mem_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cache_dout, cache_valid, cache_dirty, cache_tag,
    input  mem_din, mem_ack,
    output cpu_dout, cpu_ack,
    output cache_addr, cache_din, cache_store, cache_edit,
    output mem_cs, mem_we, mem_addr, mem_dout
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output cache_dout, cache_valid, cache_dirty, cache_tag,
    output mem_din, mem_ack,
    input  cpu_dout, cpu_ack,
    input  cache_addr, cache_din, cache_store, cache_edit,
    input  mem_cs, mem_we, mem_addr, mem_dout
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back cache controller, 4 words per line.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - cache_controller_if.master: CPU request/ack, data-array
//          address/write strobes (array reads have 1-cycle latency),
//          memory request/ack for writeback and refill.
//
// state  | meaning
// IDLE   | waiting for cpu_req; array addressed with cpu_addr
// LOOKUP | compare array tag of latched address, complete hits
// WB_RD  | address victim word k in the array
// WB_WR  | write victim word k to memory, wait mem_ack
// REFILL | read word k from memory into the array, wait mem_ack
module cache_controller #(
  parameter int ADDR_BITS        = 32,
  parameter int WORD_BITS        = 32,
  parameter int TAG_BITS         = 22,
  parameter int WORD_BYTES_WIDTH = 2,
  parameter int LINE_WORDS_WIDTH = 2
) (
  input  logic clk,
  input  logic rst,
  cache_controller_if.master bus
);
  localparam int OFF_BITS = LINE_WORDS_WIDTH + WORD_BYTES_WIDTH;
  localparam int IDX_BITS = ADDR_BITS - TAG_BITS - OFF_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_RD, WB_WR, REFILL} state_t;

  state_t                      state;
  logic [ADDR_BITS-1:0]        req_addr;
  logic                        req_we;
  logic [WORD_BITS-1:0]        req_din;
  logic [TAG_BITS-1:0]         victim_tag;
  logic [LINE_WORDS_WIDTH-1:0] k;
  logic                        settle;
  logic                        cpu_ack_q;
  logic [WORD_BITS-1:0]        cpu_dout_q;

  logic [TAG_BITS-1:0]  req_tag;
  logic [IDX_BITS-1:0]  req_idx;
  logic                 hit;
  logic                 last_word;
  logic [ADDR_BITS-1:0] line_addr;
  logic [ADDR_BITS-1:0] wb_addr;
  logic [ADDR_BITS-1:0] rf_addr;

  assign req_tag   = req_addr[ADDR_BITS-1 -: TAG_BITS];
  assign req_idx   = req_addr[OFF_BITS +: IDX_BITS];
  assign hit       = bus.cache_valid && (bus.cache_tag == req_tag);
  assign last_word = &k;
  assign line_addr = {{TAG_BITS{1'b0}}, req_idx, k, {WORD_BYTES_WIDTH{1'b0}}};
  assign wb_addr   = {victim_tag, req_idx, k, {WORD_BYTES_WIDTH{1'b0}}};
  assign rf_addr   = {req_tag, req_idx, k, {WORD_BYTES_WIDTH{1'b0}}};

  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.cpu_dout = cpu_dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_we     <= 1'b0;
      req_din    <= '0;
      victim_tag <= '0;
      k          <= '0;
      settle     <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            req_addr <= bus.cpu_addr;
            req_we   <= bus.cpu_we;
            req_din  <= bus.cpu_din;
            settle   <= 1'b0;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          // After a refill the array last saw the refill address, so spend
          // one cycle re-reading the requested word before comparing.
          if (settle) begin
            settle <= 1'b0;
          end else if (hit) begin
            if (!req_we) cpu_dout_q <= bus.cache_dout;
            cpu_ack_q <= 1'b1;
            state     <= IDLE;
          end else if (bus.cache_valid && bus.cache_dirty) begin
            victim_tag <= bus.cache_tag;
            k          <= '0;
            state      <= WB_RD;
          end else begin
            k     <= '0;
            state <= REFILL;
          end
        end
        WB_RD: state <= WB_WR;
        WB_WR: begin
          if (bus.mem_ack) begin
            if (last_word) begin
              k     <= '0;
              state <= REFILL;
            end else begin
              k     <= k + LINE_WORDS_WIDTH'(1);
              state <= WB_RD;
            end
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            if (last_word) begin
              k      <= '0;
              settle <= 1'b1;
              state  <= LOOKUP;
            end else begin
              k <= k + LINE_WORDS_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cache_addr  = '0;
    bus.cache_din   = '0;
    bus.cache_store = 1'b0;
    bus.cache_edit  = 1'b0;
    bus.mem_cs      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_dout    = '0;
    case (state)
      // Gated by rst so every output reads 0 while reset is held.
      IDLE: bus.cache_addr = rst ? bus.cpu_addr : '0;
      LOOKUP: begin
        bus.cache_addr = req_addr;
        if (!settle && hit && req_we) begin
          bus.cache_edit = 1'b1;
          bus.cache_din  = req_din;
        end
      end
      WB_RD: bus.cache_addr = line_addr;
      WB_WR: begin
        // Address held so the array keeps presenting the same victim word.
        bus.cache_addr = line_addr;
        bus.mem_cs     = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_addr   = wb_addr;
        bus.mem_dout   = bus.cache_dout;
      end
      REFILL: begin
        bus.cache_addr = req_addr;
        bus.mem_cs     = 1'b1;
        bus.mem_addr   = rf_addr;
        if (bus.mem_ack) begin
          bus.cache_store = 1'b1;
          bus.cache_addr  = rf_addr;
          bus.cache_din   = bus.mem_din;
        end
      end
      default: ;
    endcase
  end
endmodule
